// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        START,
        DATA,
        STOP
    } state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_bit_end
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear || (r_count == LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_bit_end = (r_count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO and serialises each byte as an 8N1/8N2 UART frame.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [5:0] n_elements,
    input  logic [7:0] fifo_dout,
    output logic       fifo_read,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_shift;
    logic [2:0] r_bit_idx;
    logic [2:0] w_bit_idx_next;
    logic       r_stop_idx;
    logic       w_stop_idx_next;
    logic       r_tx;
    logic       w_tx_next;
    logic       w_frame_done;
    logic       w_bit_end;
    logic       w_clear;
    logic       w_can_start;
    logic       w_stop_last;

    // Timer restarts on every state entry so each bit gets a full period.
    assign w_clear = (w_state_next != r_state) || (r_state == IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .i_clk    (clock),
        .i_rst    (reset),
        .i_clear  (w_clear),
        .o_bit_end(w_bit_end)
    );

    assign w_can_start = enable && (n_elements != 6'd0);
    assign w_stop_last = (STOP_BITS == 1) ? 1'b1 : r_stop_idx;

    always_comb begin
        w_state_next    = r_state;
        w_bit_idx_next  = r_bit_idx;
        w_stop_idx_next = r_stop_idx;
        w_frame_done    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_can_start) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                w_state_next = LATCH;
            end
            LATCH: begin
                w_state_next = START;
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_bit_idx_next = r_bit_idx + 1'b1;
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_next    = STOP;
                        w_stop_idx_next = 1'b0;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (w_stop_last) begin
                        w_frame_done    = 1'b1;
                        w_stop_idx_next = 1'b0;
                        w_state_next    = w_can_start ? FETCH : IDLE;
                    end else begin
                        w_stop_idx_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Line level is chosen from the upcoming state so tx is a pure register.
    always_comb begin
        w_tx_next = IDLE_LEVEL;
        if (w_state_next == START) begin
            w_tx_next = 1'b0;
        end else if (w_state_next == DATA) begin
            w_tx_next = r_shift[w_bit_idx_next];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_tx       <= IDLE_LEVEL;
        end else begin
            r_state    <= w_state_next;
            r_bit_idx  <= w_bit_idx_next;
            r_stop_idx <= w_stop_idx_next;
            r_tx       <= w_tx_next;
            if (r_state == LATCH) begin
                r_shift <= fifo_dout;
            end
        end
    end

    assign fifo_read  = (r_state == FETCH);
    assign busy       = (r_state != IDLE);
    assign frame_done = w_frame_done;
    assign tx         = r_tx;

endmodule
